// File: rtl/d2_5enc_tx.sv
// Serial 2-of-5 encoder/transmitter: BCD digits in over valid/ready, 2-of-5
// codewords out MSB-first on one serial line with a first-bit marker.
module d2_5enc_tx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sout,
  output logic       sout_valid,
  output logic       sout_first,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       dbg_state
);

  // Handshake: a digit transfers on a rising edge where din_valid & din_ready.
  // din_ready is low exactly while the holding register is full.

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] PER_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [4:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] per_q, per_d;
  logic       din_ready_q, din_ready_d;
  logic       sout_q, sout_d;
  logic       sout_valid_q, sout_valid_d;
  logic       sout_first_q, sout_first_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       accept, digit_ok, load;

  function automatic logic [4:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 5'b01100;
      4'd1:    enc = 5'b11000;
      4'd2:    enc = 5'b10100;
      4'd3:    enc = 5'b10010;
      4'd4:    enc = 5'b01010;
      4'd5:    enc = 5'b00110;
      4'd6:    enc = 5'b10001;
      4'd7:    enc = 5'b01001;
      4'd8:    enc = 5'b00101;
      4'd9:    enc = 5'b00011;
      default: enc = 5'b00000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    per_d       = per_q;
    load        = 1'b0;
    accept      = din_valid & ~hold_full_q;
    digit_ok    = (din <= 4'd9);

    if (accept && digit_ok) begin
      hold_d      = enc(din);
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (per_q == PER_LAST) begin
          per_d = 8'd0;
          if (bit_q == 3'd4) begin
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            shift_d = {shift_q[3:0], 1'b0};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          per_d = per_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load and accept are mutually exclusive: one needs hold_full, the other its absence.
    if (load) begin
      shift_d     = hold_q;
      bit_d       = 3'd0;
      per_d       = 8'd0;
      hold_full_d = 1'b0;
      state_d     = SHIFT;
    end

    err_d     = accept & ~digit_ok;
    err_cnt_d = (err_d && err_cnt_q != 8'd255) ? err_cnt_q + 8'd1 : err_cnt_q;

    din_ready_d  = ~hold_full_d;
    sout_valid_d = (state_d == SHIFT);
    sout_d       = (state_d == SHIFT) & shift_d[4];
    sout_first_d = (state_d == SHIFT) && (bit_d == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= 5'd0;
      hold_full_q  <= 1'b0;
      shift_q      <= 5'd0;
      bit_q        <= 3'd0;
      per_q        <= 8'd0;
      din_ready_q  <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      per_q        <= per_d;
      din_ready_q  <= din_ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_first_q <= sout_first_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_first = sout_first_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign dbg_state  = (state_q == SHIFT);

endmodule

// File: tb/tb_d2_5enc_tx.sv
// Directed bench for d2_5enc_tx: one instance at CLKS_PER_BIT=1, one at 3.
module tb_d2_5enc_tx;

  logic       clk;
  logic       rst1_n, rst3_n;
  logic [3:0] din1, din3;
  logic       din1_valid, din3_valid;
  logic       rdy1, sout1, sv1, sf1, err1, dbg1;
  logic       rdy3, sout3, sv3, sf3, err3, dbg3;
  logic [7:0] cnt1, cnt3;

  int checks;
  int failures;

  logic [4:0] code_tbl [10];

  d2_5enc_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .din(din1), .din_valid(din1_valid),
    .din_ready(rdy1), .sout(sout1), .sout_valid(sv1), .sout_first(sf1),
    .err(err1), .err_cnt(cnt1), .dbg_state(dbg1)
  );

  d2_5enc_tx #(.CLKS_PER_BIT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .din(din3), .din_valid(din3_valid),
    .din_ready(rdy3), .sout(sout3), .sout_valid(sv3), .sout_first(sf3),
    .err(err3), .err_cnt(cnt3), .dbg_state(dbg3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_sout"}, 32'(sout1), 32'd0);
    chk({tag, "_sv"}, 32'(sv1), 32'd0);
    chk({tag, "_sf"}, 32'(sf1), 32'd0);
    chk({tag, "_rdy"}, 32'(rdy1), 32'd1);
    chk({tag, "_err"}, 32'(err1), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt1), 32'd0);
  endtask

  // Accept one digit on dut1, then check the 5-cycle frame that follows.
  task automatic send_frame1(input string tag, input logic [3:0] d, input logic [4:0] code);
    din1 = d;
    din1_valid = 1'b1;
    step();
    din1_valid = 1'b0;
    chk({tag, "_rdy_low"}, 32'(rdy1), 32'd0);
    chk({tag, "_sv_pre"}, 32'(sv1), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("%s_sv%0d", tag, k), 32'(sv1), 32'd1);
      chk($sformatf("%s_bit%0d", tag, k), 32'(sout1), 32'(code[4-k]));
      chk($sformatf("%s_sf%0d", tag, k), 32'(sf1), (k == 0) ? 32'd1 : 32'd0);
    end
    step();
    chk({tag, "_sv_post"}, 32'(sv1), 32'd0);
  endtask

  initial begin
    int idx, seen;
    logic pres;
    checks = 0;
    failures = 0;
    code_tbl[0] = 5'b01100; code_tbl[1] = 5'b11000; code_tbl[2] = 5'b10100;
    code_tbl[3] = 5'b10010; code_tbl[4] = 5'b01010; code_tbl[5] = 5'b00110;
    code_tbl[6] = 5'b10001; code_tbl[7] = 5'b01001; code_tbl[8] = 5'b00101;
    code_tbl[9] = 5'b00011;

    rst1_n = 1'b0; rst3_n = 1'b0;
    din1 = 4'd0; din1_valid = 1'b0;
    din3 = 4'd0; din3_valid = 1'b0;
    step();
    step();
    chk_reset1("reset");
    rst1_n = 1'b1; rst3_n = 1'b1;
    step();

    // single digit 3 -> 10010
    send_frame1("d3", 4'd3, 5'b10010);

    // stream 0..9 with valid held whenever ready
    idx = 0;
    seen = 0;
    for (int cyc = 0; cyc < 80 && seen < 50; cyc++) begin
      pres = 1'b0;
      din1_valid = 1'b0;
      if (idx < 10 && rdy1) begin
        din1 = 4'(idx);
        din1_valid = 1'b1;
        pres = 1'b1;
      end
      step();
      if (pres) idx++;
      if (seen > 0 && seen < 50) chk($sformatf("stream_gap%0d", seen), 32'(sv1), 32'd1);
      if (sv1) begin
        chk($sformatf("stream_bit%0d", seen), 32'(sout1), 32'(code_tbl[seen/5][4-(seen%5)]));
        chk($sformatf("stream_sf%0d", seen), 32'(sf1), (seen % 5 == 0) ? 32'd1 : 32'd0);
        seen++;
      end
    end
    din1_valid = 1'b0;
    chk("stream_count", 32'(seen), 32'd50);
    step();
    chk("stream_end_sv", 32'(sv1), 32'd0);

    // invalid digit 12
    din1 = 4'd12;
    din1_valid = 1'b1;
    step();
    din1_valid = 1'b0;
    chk("inv_err", 32'(err1), 32'd1);
    chk("inv_cnt", 32'(cnt1), 32'd1);
    chk("inv_rdy", 32'(rdy1), 32'd1);
    chk("inv_sv", 32'(sv1), 32'd0);
    step();
    chk("inv_err_clr", 32'(err1), 32'd0);
    chk("inv_sv2", 32'(sv1), 32'd0);
    send_frame1("d7", 4'd7, 5'b01001);

    // saturation: 260 invalid digits back to back
    for (int i = 0; i < 260; i++) begin
      din1 = 4'(10 + (i % 6));
      din1_valid = 1'b1;
      step();
      chk($sformatf("sat_err%0d", i), 32'(err1), 32'd1);
      chk($sformatf("sat_cnt%0d", i), 32'(cnt1), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
    end
    din1_valid = 1'b0;
    step();
    chk("sat_err_clr", 32'(err1), 32'd0);
    chk("sat_hold", 32'(cnt1), 32'd255);
    chk("sat_sv", 32'(sv1), 32'd0);

    // async reset mid-frame on dut1
    din1 = 4'd5;
    din1_valid = 1'b1;
    step();
    din1_valid = 1'b0;
    step();
    step();
    chk("ar_pre_sv", 32'(sv1), 32'd1);
    #2 rst1_n = 1'b0;
    #1;
    chk_reset1("ar");
    chk("ar_state", 32'(dbg1), 32'd0);
    step();
    rst1_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("ar_quiet%0d", k), 32'(sv1), 32'd0);
    end
    send_frame1("ar_d1", 4'd1, 5'b11000);

    // CLKS_PER_BIT=3: digit 9 -> 00011, each bit held 3 cycles
    din3 = 4'd9;
    din3_valid = 1'b1;
    step();
    din3_valid = 1'b0;
    chk("c3_rdy_low", 32'(rdy3), 32'd0);
    chk("c3_sv_pre", 32'(sv3), 32'd0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("c3_sv%0d", k), 32'(sv3), 32'd1);
      chk($sformatf("c3_bit%0d", k), 32'(sout3), (k >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("c3_sf%0d", k), 32'(sf3), (k < 3) ? 32'd1 : 32'd0);
    end
    step();
    chk("c3_sv_post", 32'(sv3), 32'd0);

    // reset at frame cycle 7
    din3 = 4'd9;
    din3_valid = 1'b1;
    step();
    din3_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("c3r_pre_sv", 32'(sv3), 32'd1);
    #2 rst3_n = 1'b0;
    #1;
    chk("c3r_sv", 32'(sv3), 32'd0);
    chk("c3r_sout", 32'(sout3), 32'd0);
    chk("c3r_sf", 32'(sf3), 32'd0);
    chk("c3r_rdy", 32'(rdy3), 32'd1);
    step();
    rst3_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("c3r_quiet%0d", k), 32'(sv3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
